alt_lcd_if: RTL

ALT_LCD_IF -- requirements
Module: alt_lcd_if

---
 rtl/alt_lcd_pkg.sv | 57 +++++
 rtl/alt_lcd_host_if.sv | 20 ++
 rtl/alt_cmd_fifo.sv | 57 +++++
 rtl/alt_lcd_if.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alt_lcd_pkg.sv
// Shared types and defaults for the character-LCD bus controller.
package alt_lcd_pkg;

  // Default parameter values for alt_lcd_if.
  localparam int DEF_DB_WIDTH     = 8;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_T_AS         = 1;
  localparam int DEF_T_EH         = 4;
  localparam int DEF_T_EL         = 4;
  localparam int DEF_BUSY_POLL    = 1;
  localparam int DEF_BUSY_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    POLL_AS,
    POLL_EH,
    POLL_EL,
    XFER_AS,
    XFER_EH,
    XFER_EL
  } state_e;

  // One queued host command.
  typedef struct packed {
    logic       read;
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  // LCD pad levels that stay constant for a whole AS/EH/EL pulse.
  // db is always 8 bits wide; only the low DB_WIDTH bits reach the pads.
  typedef struct packed {
    logic       rs;
    logic       rnw;
    logic       n_en;
    logic [7:0] db;
  } pins_t;

  // Bus released: used while idle and for every busy-flag poll.
  localparam pins_t PINS_RELEASED = '{rs: 1'b0, rnw: 1'b1, n_en: 1'b1, db: 8'h00};

  // Pad levels for one transfer pulse; in 4-bit mode nib=0 selects the high nibble.
  function automatic pins_t xfer_pins(cmd_t c, logic nib, int dbw);
    pins_t p;
    p.rs   = c.rs;
    p.rnw  = c.read;
    p.n_en = c.read;
    if (c.read)
      p.db = 8'h00;
    else if (dbw == 4)
      p.db = nib ? {4'h0, c.data[3:0]} : {4'h0, c.data[7:4]};
    else
      p.db = c.data;
    return p;
  endfunction

endpackage

// File: rtl/alt_lcd_host_if.sv
// Host-side command/response bus of the LCD controller.
interface alt_lcd_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_read;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_read, cmd_rs, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_rs, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alt_cmd_fifo.sv
// Small first-word-fall-through command FIFO. Exposes the entry behind the
// head as well so the controller can chain commands without an idle gap.
module alt_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_next,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because the count gates them.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[r_rd_ptr + 1'b1];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/alt_lcd_if.sv
// HD44780-style LCD bus controller: queues host commands, optionally polls the
// busy flag, then runs timed AS/EH/EL enable pulses on a 4- or 8-bit bus.
module alt_lcd_if
  import alt_lcd_pkg::*;
#(
  parameter int DB_WIDTH     = DEF_DB_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int T_AS         = DEF_T_AS,
  parameter int T_EH         = DEF_T_EH,
  parameter int T_EL         = DEF_T_EL,
  parameter int BUSY_POLL    = DEF_BUSY_POLL,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                Clock,
  input  logic                Reset,
  alt_lcd_host_if.slave       host,
  output logic                busy_timeout,
  output logic                idle,
  output logic                RS,
  output logic                RnW,
  output logic                E,
  input  logic [DB_WIDTH-1:0] DB_In,
  output logic [DB_WIDTH-1:0] DB_Out,
  output logic                DB_nEnable
);
  localparam int  T_MAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                        : ((T_EH > T_EL) ? T_EH : T_EL);
  localparam int  TW       = $clog2(T_MAX) + 1;
  localparam int  PW       = $clog2(BUSY_TIMEOUT + 1);
  localparam int  CW       = $clog2(FIFO_DEPTH) + 1;
  localparam bit  NIB_MODE = (DB_WIDTH == 4);

  state_e        r_state;
  logic [TW-1:0] r_cnt;
  logic [PW-1:0] r_poll;
  logic          r_nib;
  logic          r_busy;
  logic          r_e;
  pins_t         r_pins;
  logic [3:0]    r_rd_hi;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_data;
  logic          r_timeout;
  logic          r_ready_en;

  cmd_t          w_push_cmd;
  cmd_t          w_head;
  cmd_t          w_next;
  cmd_t          w_next_cmd;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_next_avail;
  logic          w_cnt_done;
  logic [7:0]    w_db_in8;

  assign w_push_cmd = '{read: host.cmd_read, rs: host.cmd_rs, data: host.cmd_data};
  assign w_push     = host.cmd_valid && host.cmd_ready;
  assign w_cnt_done = (r_cnt == '0);
  assign w_db_in8   = 8'(DB_In);

  // The head leaves the FIFO on the edge that ends its final EL cycle.
  assign w_pop = (r_state == XFER_EL) && w_cnt_done && (!NIB_MODE || r_nib);

  // Command that follows the popped head: the queued second entry, or a
  // command being pushed on the very same edge into a one-entry FIFO.
  assign w_next_avail = (w_count > CW'(1)) || w_push;
  assign w_next_cmd   = (w_count > CW'(1)) ? w_next : w_push_cmd;

  alt_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clock),
    .srst    (Reset),
    .i_push  (w_push),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Hold cmd_ready low on reset edges; it reopens on the first edge out of reset.
  always_ff @(posedge Clock) begin
    r_ready_en <= !Reset;
  end

  // Bus sequencer: state, pulse timing, nibble/poll counters and all pad outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_poll      <= '0;
      r_nib       <= 1'b0;
      r_busy      <= 1'b0;
      r_e         <= 1'b0;
      r_pins      <= PINS_RELEASED;
      r_rd_hi     <= 4'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_timeout   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_cnt  <= TW'(T_AS - 1);
            r_nib  <= 1'b0;
            r_poll <= '0;
            if (BUSY_POLL != 0) begin
              r_state <= POLL_AS;
              r_pins  <= PINS_RELEASED;
            end else begin
              r_state <= XFER_AS;
              r_pins  <= xfer_pins(w_head, 1'b0, DB_WIDTH);
            end
          end
        end
        POLL_AS, XFER_AS: begin
          if (w_cnt_done) begin
            r_state <= (r_state == POLL_AS) ? POLL_EH : XFER_EH;
            r_cnt   <= TW'(T_EH - 1);
            r_e     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        POLL_EH: begin
          if (w_cnt_done) begin
            r_state <= POLL_EL;
            r_cnt   <= TW'(T_EL - 1);
            r_e     <= 1'b0;
            // Busy flag lives in the first (high) nibble in 4-bit mode.
            if (!r_nib) r_busy <= w_db_in8[DB_WIDTH-1];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        XFER_EH: begin
          if (w_cnt_done) begin
            r_state <= XFER_EL;
            r_cnt   <= TW'(T_EL - 1);
            r_e     <= 1'b0;
            if (w_head.read) begin
              if (NIB_MODE && !r_nib) begin
                r_rd_hi <= w_db_in8[3:0];
              end else begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= NIB_MODE ? {r_rd_hi, w_db_in8[3:0]} : w_db_in8;
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        POLL_EL: begin
          if (w_cnt_done) begin
            r_cnt <= TW'(T_AS - 1);
            if (NIB_MODE && !r_nib) begin
              r_nib   <= 1'b1;
              r_state <= POLL_AS;
            end else begin
              r_nib <= 1'b0;
              if (r_busy && (r_poll != PW'(BUSY_TIMEOUT - 1))) begin
                r_poll  <= r_poll + 1'b1;
                r_state <= POLL_AS;
              end else begin
                // Either the LCD is ready or we gave up waiting on it.
                if (r_busy) r_timeout <= 1'b1;
                r_poll  <= '0;
                r_state <= XFER_AS;
                r_pins  <= xfer_pins(w_head, 1'b0, DB_WIDTH);
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        XFER_EL: begin
          if (w_cnt_done) begin
            r_cnt <= TW'(T_AS - 1);
            if (NIB_MODE && !r_nib) begin
              r_nib   <= 1'b1;
              r_state <= XFER_AS;
              r_pins  <= xfer_pins(w_head, 1'b1, DB_WIDTH);
            end else begin
              r_nib  <= 1'b0;
              r_poll <= '0;
              if (!w_next_avail) begin
                r_state <= IDLE;
                r_pins  <= PINS_RELEASED;
              end else if (BUSY_POLL != 0) begin
                r_state <= POLL_AS;
                r_pins  <= PINS_RELEASED;
              end else begin
                r_state <= XFER_AS;
                r_pins  <= xfer_pins(w_next_cmd, 1'b0, DB_WIDTH);
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign host.cmd_ready = r_ready_en && !w_full;
  assign host.rsp_valid = r_rsp_valid;
  assign host.rsp_data  = r_rsp_data;
  assign busy_timeout   = r_timeout;
  assign idle           = (r_state == IDLE) && w_empty;
  assign RS             = r_pins.rs;
  assign RnW            = r_pins.rnw;
  assign DB_nEnable     = r_pins.n_en;
  assign DB_Out         = r_pins.db[DB_WIDTH-1:0];
  assign E              = r_e;
endmodule
